uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
Shares the bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the top-level tile between two internal requesters. Requesters may drive (write) or sample (read) the pads.
- Arbitration is round-robin with a bounded burst length.
- A tri-stated turnaround gap is inserted whenever the bus direction changes.
- Sits directly between the tile's uio pins and the internal functional units. Gated by the tile's ena.

Parameters:
MAX_BURST, 4, maximum beats per grant (1..15)
TURN_CYC, 1, idle cycles with uio_oe=0 inserted on a direction change (0..3)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; low forces the bus idle
req  input  2  request, one bit per requester (bit i = requester i)
req_dir  input  2  per-requester direction: 1=write (drive pads), 0=read
req_wdata  input  16  write data; [7:0] requester 0, [15:8] requester 1
gnt  output  2  registered one-hot grant
rvalid  output  2  one-cycle pulse; rdata is valid for that requester
rdata  output  8  registered sample of uio_in
uio_in  input  8  pad input path
uio_out  output  8  pad output path
uio_oe  output  8  pad output enable (1=drive)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. All state is in flops.
- Reset values:
  - state=IDLE, gnt=0, rvalid=0, rdata=0, uio_out=0, uio_oe=0.
  - last_gnt=1, so requester 0 wins the first arbitration.
  - last_dir=0 (read).
- States: IDLE, TURN, GRANT.
- IDLE, when ena=1 and req!=0:
  - Pick winner w. If exactly one bit is set, that requester wins. If both are set, w = ~last_gnt.
  - Latch w, set dir_q=req_dir[w], set last_gnt=w, clear beat counter.
  - If dir_q!=last_dir and TURN_CYC>0: go to TURN with turn_cnt=TURN_CYC-1. Otherwise go to GRANT.
  - last_dir<=dir_q.
- TURN:
  - gnt=0, uio_oe=0.
  - When turn_cnt==0, go to GRANT; otherwise decrement turn_cnt.
- GRANT:
  - gnt[w]=1 in every GRANT cycle. gnt is 0 in all other states.
  - Beat: a cycle with state==GRANT and req[w]=1.
  - Write beat at cycle t: at t+1, uio_out=req_wdata[w], uio_oe=8'hFF.
  - Read beat at t: at t+1, rdata=uio_in sampled at t and rvalid[w]=1.
  - uio_oe is 8'hFF only in the cycle after a write beat, otherwise 0. uio_out holds its last value.
  - Exit to IDLE (gnt drops the next cycle) when either condition holds:
    - req[w]=0 in a GRANT cycle (no beat that cycle), or
    - the MAX_BURST-th beat completes.
- Fixed per grant:
  - req_dir changes during TURN/GRANT are ignored; dir_q is fixed for the grant.
  - The non-winner's req is ignored until the next IDLE.
- Fairness: a requester holding req continuously is preempted after MAX_BURST beats. The other requester, if pending, wins the next IDLE arbitration.
- Back-to-back: each grant is separated by at least one IDLE cycle, plus TURN_CYC cycles if the direction changes.
- ena=0 in any state:
  - Next cycle: state=IDLE, gnt=0, uio_oe=0, rvalid=0. A pending beat in that cycle is dropped.
  - No arbitration while ena=0.
  - last_gnt/last_dir are retained.
- Asynchronous reset mid-grant: all outputs return to reset values immediately; pads are tri-stated.
- Invariants:
  - At most one gnt bit set.
  - At most one rvalid bit set.
  - uio_oe is never 8'hFF during a read grant.

Decomposition:
- Package uio_arb_pkg:
  - state enum {IDLE, TURN, GRANT}
  - constants DIR_READ=0, DIR_WRITE=1
  - OE_ALL=8'hFF, OE_NONE=8'h00
  - counter widths derived from MAX_BURST/TURN_CYC
- Sub-module rr_arb2: combinational 2-way round-robin pick (req[1:0], last_gnt) -> (valid, winner). The FSM, counters and pad registers stay in uio_bus_arbiter.

Test Plan:
- Reset/idle: hold rst_n=0, then release with req=0 -> gnt=0, uio_oe=0, uio_out=0, rvalid=0 for 10 cycles.
- Single write burst, defaults: ena=1; req0=1, dir0=1, wdata0=8'hA5 held; first arbitration is a direction change from read.
  - IDLE, then 1 TURN cycle.
  - gnt=01 for exactly 4 cycles.
  - uio_out=A5 with uio_oe=FF for 4 cycles, lagging gnt by 1.
  - Then a 1-cycle IDLE gap and re-grant to requester 0.
- Round-robin with contention: both req held; dir0=1, dir1=0; uio_in=8'h3C.
  - Grants alternate 0,1,0, with a TURN cycle before each switch.
  - Requester 1 sees rvalid=10 with rdata=3C on 4 cycles per grant.
  - uio_oe=00 throughout requester 1's grants.
- Early release: req1 read granted; drop req1 after 2 beats -> exactly 2 rvalid pulses, gnt drops the next cycle, state returns to IDLE.
- ena drop mid-write: during requester 0's grant, set ena=0 for 3 cycles.
  - Next cycle: gnt=0, uio_oe=00.
  - No grants while ena is low.
  - On ena=1 with req0 still held, requester 0 is re-granted without a TURN (last_dir=write).
- TURN_CYC=0, MAX_BURST=1 build: alternating read/write requests -> no TURN state, 1 beat per grant, 1 IDLE cycle between grants.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Counter widths cover the full legal MAX_BURST / TURN_CYC ranges.
package uio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      GRANT = 2'd2
   } arb_state_e;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   localparam logic [7:0] OE_ALL  = 8'hFF;
   localparam logic [7:0] OE_NONE = 8'h00;

   localparam int MAX_BURST_LIM = 15;
   localparam int TURN_CYC_LIM  = 3;
   localparam int BEAT_W = $clog2(MAX_BURST_LIM + 1);
   localparam int TURN_W = $clog2(TURN_CYC_LIM + 1);

   function automatic logic [1:0] onehot2(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins,
// on contention the one not granted last time wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       valid,
   output logic       winner
);

   // combinational winner selection
   always_comb begin
      valid  = |req;
      winner = 1'b0;
      unique case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_gnt;
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the uio pad bus between two requesters with round-robin,
// bounded bursts and a tri-stated turnaround on direction change.
module uio_bus_arbiter
   import uio_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int TURN_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [1:0]  req,
   input  logic [1:0]  req_dir,
   input  logic [15:0] req_wdata,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [7:0]  rdata,
   input  logic [7:0]  uio_in,
   output logic [7:0]  uio_out,
   output logic [7:0]  uio_oe
);

   arb_state_e        state_q, state_d;
   logic              win_q, win_d;
   logic              dir_q, dir_d;
   logic              last_gnt_q, last_gnt_d;
   logic              last_dir_q, last_dir_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [TURN_W-1:0] turn_q, turn_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [7:0]        uio_out_q, uio_out_d;
   logic [7:0]        uio_oe_q, uio_oe_d;

   logic              arb_valid;
   logic              arb_win;
   logic [7:0]        wbyte;

   rr_arb2 u_rr (
      .req      (req),
      .last_gnt (last_gnt_q),
      .valid    (arb_valid),
      .winner   (arb_win)
   );

   assign wbyte = win_q ? req_wdata[15:8] : req_wdata[7:0];

   // next-state, counters and pad/read registers
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      dir_d      = dir_q;
      last_gnt_d = last_gnt_q;
      last_dir_d = last_dir_q;
      beat_d     = beat_q;
      turn_d     = turn_q;
      rdata_d    = rdata_q;
      uio_out_d  = uio_out_q;
      rvalid_d   = 2'b00;
      uio_oe_d   = OE_NONE;
      gnt_d      = 2'b00;

      if (!ena) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  win_d      = arb_win;
                  dir_d      = req_dir[arb_win];
                  last_gnt_d = arb_win;
                  last_dir_d = req_dir[arb_win];
                  beat_d     = '0;
                  if (req_dir[arb_win] != last_dir_q && TURN_CYC > 0) begin
                     state_d = TURN;
                     turn_d  = TURN_W'(TURN_CYC - 1);
                  end else begin
                     state_d = GRANT;
                  end
               end
            end
            TURN: begin
               if (turn_q == '0) begin
                  state_d = GRANT;
               end else begin
                  turn_d = turn_q - 1'b1;
               end
            end
            GRANT: begin
               if (!req[win_q]) begin
                  state_d = IDLE;
               end else begin
                  if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
                     state_d = IDLE;
                  end else begin
                     beat_d = beat_q + 1'b1;
                  end
                  if (dir_q == DIR_WRITE) begin
                     uio_out_d = wbyte;
                     uio_oe_d  = OE_ALL;
                  end else begin
                     rdata_d  = uio_in;
                     rvalid_d = onehot2(win_q);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (state_d == GRANT) begin
         gnt_d = onehot2(win_d);
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         win_q      <= 1'b0;
         dir_q      <= DIR_READ;
         last_gnt_q <= 1'b1;
         last_dir_q <= DIR_READ;
         beat_q     <= '0;
         turn_q     <= '0;
         gnt_q      <= 2'b00;
         rvalid_q   <= 2'b00;
         rdata_q    <= 8'h00;
         uio_out_q  <= 8'h00;
         uio_oe_q   <= OE_NONE;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         dir_q      <= dir_d;
         last_gnt_q <= last_gnt_d;
         last_dir_q <= last_dir_d;
         beat_q     <= beat_d;
         turn_q     <= turn_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         uio_out_q  <= uio_out_d;
         uio_oe_q   <= uio_oe_d;
      end
   end

   assign gnt     = gnt_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign uio_out = uio_out_q;
   assign uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: directed phases then
// random traffic against a behavioural bus-ownership model.
module tb_uio_bus_arbiter;

   localparam int MB = 4;
   localparam int TC = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [1:0]  req;
   logic [1:0]  req_dir;
   logic [15:0] req_wdata;
   logic [7:0]  uio_in;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [7:0]  rdata;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;

   uio_bus_arbiter #(
      .MAX_BURST (MB),
      .TURN_CYC  (TC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .req       (req),
      .req_dir   (req_dir),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .uio_in    (uio_in),
      .uio_out   (uio_out),
      .uio_oe    (uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] gnt;
      logic [1:0] rvalid;
      logic [7:0] rdata;
      logic [7:0] uio_out;
      logic [7:0] uio_oe;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: who owns the bus, how many turnaround
   // cycles remain before data moves, and how many beats moved.
   int         m_own;
   int         m_gap;
   int         m_beats;
   int         m_last;
   logic       m_ldir;
   logic       m_dir;
   logic [7:0] m_rdata;
   logic [7:0] m_out;

   task automatic model_reset();
      m_own = -1; m_gap = 0; m_beats = 0; m_last = 1;
      m_ldir = 1'b0; m_dir = 1'b0; m_rdata = 8'h00; m_out = 8'h00;
   endtask

   task automatic step();
      exp_t e;
      e.cyc    = cyc + 1;
      e.rvalid = 2'b00;
      e.uio_oe = 8'h00;
      if (!ena) begin
         m_own = -1;
      end else if (m_own < 0) begin
         if (req != 2'b00) begin
            int w;
            if (req == 2'b11) w = 1 - m_last;
            else w = req[1] ? 1 : 0;
            m_last  = w;
            m_own   = w;
            m_dir   = req_dir[w];
            m_beats = 0;
            m_gap   = (m_dir != m_ldir) ? TC : 0;
            m_ldir  = m_dir;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req[m_own]) begin
         if (m_dir) begin
            m_out    = req_wdata[8*m_own +: 8];
            e.uio_oe = 8'hFF;
         end else begin
            m_rdata          = uio_in;
            e.rvalid[m_own]  = 1'b1;
         end
         m_beats++;
         if (m_beats == MB) m_own = -1;
      end else begin
         m_own = -1;
      end
      e.gnt = 2'b00;
      if (m_own >= 0 && m_gap == 0) e.gnt[m_own] = 1'b1;
      e.rdata   = m_rdata;
      e.uio_out = m_out;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 2'b00;
      ena = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'({gnt, rvalid, rdata, uio_out, uio_oe}), 64'd0);
      exp_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // monitor: compare the DUT against the expected record for this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_cycle", 64'(e.cyc), 64'(cyc));
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("outputs", 64'({gnt, rvalid, rdata, uio_out, uio_oe}),
                  64'({e.gnt, e.rvalid, e.rdata, e.uio_out, e.uio_oe}));
            check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            check("rvalid_onehot0", 64'($onehot0(rvalid)), 64'd1);
         end
      end
   end

   initial begin
      int rv;
      int bad;
      ena = 1'b0; req = 2'b00; req_dir = 2'b00;
      req_wdata = 16'h0000; uio_in = 8'h00;
      model_reset();
      rst_n = 1'b1;
      #2;
      do_reset();

      ena = 1'b1;
      bad = 0;
      repeat (10) begin
         step();
         if ({gnt, rvalid, uio_out, uio_oe} != 26'd0) bad++;
      end
      check("idle_quiet", 64'(bad), 64'd0);

      do_reset();
      ena = 1'b1; req = 2'b01; req_dir = 2'b01; req_wdata = 16'h00A5;
      step();
      check("wr_turn_gnt", 64'(gnt), 64'd0);
      step();
      check("wr_first_gnt", 64'(gnt), 64'd1);
      step();
      check("wr_pads", 64'({uio_oe, uio_out}), 64'h0000_FFA5);
      repeat (12) step();

      do_reset();
      ena = 1'b1; req = 2'b11; req_dir = 2'b01; uio_in = 8'h3C;
      req_wdata = 16'h5501;
      rv = 0; bad = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         if (rvalid == 2'b10 && rdata == 8'h3C) rv++;
         if (gnt == 2'b10 && uio_oe != 8'h00) bad++;
      end
      check("rr_reads", 64'(rv), 64'd8);
      check("rr_read_oe", 64'(bad), 64'd0);

      do_reset();
      ena = 1'b1; req = 2'b10; req_dir = 2'b00; uio_in = 8'h5A;
      rv = 0;
      repeat (3) begin
         step();
         if (rvalid == 2'b10) rv++;
      end
      req = 2'b00;
      step();
      check("early_gnt_drop", 64'(gnt), 64'd0);
      repeat (3) begin
         step();
         if (rvalid != 2'b00) rv++;
      end
      check("early_reads", 64'(rv), 64'd2);

      do_reset();
      ena = 1'b1; req = 2'b01; req_dir = 2'b01; req_wdata = 16'h0077;
      repeat (4) step();
      ena = 1'b0;
      step();
      check("ena_drop", 64'({gnt, uio_oe}), 64'd0);
      bad = 0;
      repeat (2) begin
         step();
         if (gnt != 2'b00) bad++;
      end
      check("ena_low_nogrant", 64'(bad), 64'd0);
      ena = 1'b1;
      step();
      check("ena_regrant", 64'(gnt), 64'd1);
      step();

      do_reset();
      ena = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
         end
         if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
         if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
         if ($urandom_range(0, 5) == 0) req_dir = 2'($urandom_range(0, 3));
         req_wdata = 16'($urandom);
         uio_in = 8'($urandom);
         ena = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
         step();
      end

      repeat (3) @(posedge clk);
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
